// File: rtl/ps2_pkg.sv
// Shared types, scancode constants and the Set-2 to Hack key translation.
// PS2_LOWERCASE_EN: when defined, unshifted letters report lowercase ASCII.
package ps2_pkg;

  typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_e;
  typedef enum logic [1:0] {DEC_NORMAL, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] KEY_NEWLINE   = 8'd128;
  localparam logic [7:0] KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] KEY_LEFT      = 8'd130;
  localparam logic [7:0] KEY_UP        = 8'd131;
  localparam logic [7:0] KEY_RIGHT     = 8'd132;
  localparam logic [7:0] KEY_DOWN      = 8'd133;
  localparam logic [7:0] KEY_HOME      = 8'd134;
  localparam logic [7:0] KEY_END       = 8'd135;
  localparam logic [7:0] KEY_PGUP      = 8'd136;
  localparam logic [7:0] KEY_PGDN      = 8'd137;
  localparam logic [7:0] KEY_INSERT    = 8'd138;
  localparam logic [7:0] KEY_DELETE    = 8'd139;
  localparam logic [7:0] KEY_ESC       = 8'd140;
  localparam logic [7:0] KEY_F1        = 8'd141;
  localparam logic [7:0] KEY_F12       = 8'd152;

  // Returns 0 for any code without a Hack mapping (including the shift keys).
  function automatic logic [15:0] ps2_translate(input logic [7:0] code, input logic ext,
                                                input logic shift);
    logic [7:0] ch;
    logic [7:0] lc_off;
    ch = 8'd0;
`ifdef PS2_LOWERCASE_EN
    lc_off = shift ? 8'd0 : 8'd32;
`else
    lc_off = 8'd0;
`endif
    if (ext) begin
      case (code)
        8'h6B: ch = KEY_LEFT;    8'h75: ch = KEY_UP;
        8'h74: ch = KEY_RIGHT;   8'h72: ch = KEY_DOWN;
        8'h6C: ch = KEY_HOME;    8'h69: ch = KEY_END;
        8'h7D: ch = KEY_PGUP;    8'h7A: ch = KEY_PGDN;
        8'h70: ch = KEY_INSERT;  8'h71: ch = KEY_DELETE;
        default: ch = 8'd0;
      endcase
    end else begin
      case (code)
        8'h1C: ch = 8'd65;  8'h32: ch = 8'd66;  8'h21: ch = 8'd67;  8'h23: ch = 8'd68;
        8'h24: ch = 8'd69;  8'h2B: ch = 8'd70;  8'h34: ch = 8'd71;  8'h33: ch = 8'd72;
        8'h43: ch = 8'd73;  8'h3B: ch = 8'd74;  8'h42: ch = 8'd75;  8'h4B: ch = 8'd76;
        8'h3A: ch = 8'd77;  8'h31: ch = 8'd78;  8'h44: ch = 8'd79;  8'h4D: ch = 8'd80;
        8'h15: ch = 8'd81;  8'h2D: ch = 8'd82;  8'h1B: ch = 8'd83;  8'h2C: ch = 8'd84;
        8'h3C: ch = 8'd85;  8'h2A: ch = 8'd86;  8'h1D: ch = 8'd87;  8'h22: ch = 8'd88;
        8'h35: ch = 8'd89;  8'h1A: ch = 8'd90;
        8'h16: ch = shift ? 8'd33  : 8'd49;
        8'h1E: ch = shift ? 8'd64  : 8'd50;
        8'h26: ch = shift ? 8'd35  : 8'd51;
        8'h25: ch = shift ? 8'd36  : 8'd52;
        8'h2E: ch = shift ? 8'd37  : 8'd53;
        8'h36: ch = shift ? 8'd94  : 8'd54;
        8'h3D: ch = shift ? 8'd38  : 8'd55;
        8'h3E: ch = shift ? 8'd42  : 8'd56;
        8'h46: ch = shift ? 8'd40  : 8'd57;
        8'h45: ch = shift ? 8'd41  : 8'd48;
        8'h0E: ch = shift ? 8'd126 : 8'd96;
        8'h4E: ch = shift ? 8'd95  : 8'd45;
        8'h55: ch = shift ? 8'd43  : 8'd61;
        8'h54: ch = shift ? 8'd123 : 8'd91;
        8'h5B: ch = shift ? 8'd125 : 8'd93;
        8'h5D: ch = shift ? 8'd124 : 8'd92;
        8'h4C: ch = shift ? 8'd58  : 8'd59;
        8'h52: ch = shift ? 8'd34  : 8'd39;
        8'h41: ch = shift ? 8'd60  : 8'd44;
        8'h49: ch = shift ? 8'd62  : 8'd46;
        8'h4A: ch = shift ? 8'd63  : 8'd47;
        8'h29: ch = 8'd32;
        8'h5A: ch = KEY_NEWLINE;
        8'h66: ch = KEY_BACKSPACE;
        8'h76: ch = KEY_ESC;
        8'h05: ch = KEY_F1;          8'h06: ch = KEY_F1 + 8'd1;
        8'h04: ch = KEY_F1 + 8'd2;   8'h0C: ch = KEY_F1 + 8'd3;
        8'h03: ch = KEY_F1 + 8'd4;   8'h0B: ch = KEY_F1 + 8'd5;
        8'h83: ch = KEY_F1 + 8'd6;   8'h0A: ch = KEY_F1 + 8'd7;
        8'h01: ch = KEY_F1 + 8'd8;   8'h09: ch = KEY_F1 + 8'd9;
        8'h78: ch = KEY_F1 + 8'd10;  8'h07: ch = KEY_F12;
        default: ch = 8'd0;
      endcase
      // Only the uppercase letters occupy 65..90 in this table.
      if (ch >= 8'd65 && ch <= 8'd90) ch = ch + lc_off;
    end
    return {8'h00, ch};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive path: pad synchronisers, deglitch filter, 11-bit frame FSM and
// watchdog. scan_valid_o / frame_err_o are one-cycle strobes with no backpressure.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       scan_valid_o,
  output logic [7:0] scan_code_o,
  output logic       frame_err_o
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
  logic [1:0]         sync1_q, sync2_q, filt_q, filt_d;
  logic [1:0][FW-1:0] cnt_q, cnt_d;
  logic               clk_prev_q;
  logic               fall, data_bit;

  frame_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          timeout, good_byte, bad_frame;
  logic          scan_valid_q;
  logic [7:0]    scan_code_q;
  logic          frame_err_q;

  // A line flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      cnt_q      <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= {ps2_data_i, ps2_clk_i};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      clk_prev_q <= filt_q[0];
    end
  end

  assign fall     = clk_prev_q & ~filt_q[0];
  assign data_bit = filt_q[1];
  assign timeout  = (state_q != FR_IDLE) && !fall && (wdog_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FR_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = FR_IDLE;
    end else if (fall) begin
      case (state_q)
        FR_IDLE:   if (!data_bit) state_d = FR_DATA;
        FR_DATA:   if (bit_cnt_q == 3'd7) state_d = FR_PARITY;
        FR_PARITY: state_d = FR_STOP;
        FR_STOP:   state_d = FR_IDLE;
        default:   state_d = FR_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    good_byte = 1'b0;
    bad_frame = timeout;
    wdog_d    = (fall || state_q == FR_IDLE) ? '0 : wdog_q + 1'b1;
    if (fall) begin
      case (state_q)
        FR_IDLE: begin
          bit_cnt_d = '0;
          if (data_bit) bad_frame = 1'b1;
        end
        FR_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        FR_PARITY: par_ok_d = ^{shift_q, data_bit};
        FR_STOP: begin
          if (data_bit && par_ok_q) good_byte = 1'b1;
          else                      bad_frame = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      wdog_q       <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      wdog_q       <= wdog_d;
      scan_valid_q <= good_byte;
      frame_err_q  <= bad_frame;
      if (good_byte) scan_code_q <= shift_q;
    end
  end

  assign scan_valid_o = scan_valid_q;
  assign scan_code_o  = scan_code_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard to Hack KBD word: frame receiver plus Set-2 make/break decoder.
// PS2_LOWERCASE_EN: when defined, unshifted letters report lowercase ASCII.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_out,
  output logic        scan_valid,
  output logic [7:0]  scan_code,
  output logic        frame_err
);

  dec_state_e  dec_state_q, dec_state_d;
  logic [15:0] key_q, key_d;
  logic [8:0]  last_make_q, last_make_d;
  logic        lshift_q, lshift_d, rshift_q, rshift_d;
  logic        is_make, is_break, ev_ext;
  logic [15:0] xlated;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (clk),
    .rst_ni      (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .scan_valid_o(scan_valid),
    .scan_code_o (scan_code),
    .frame_err_o (frame_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dec_state_q <= DEC_NORMAL;
    else        dec_state_q <= dec_state_d;
  end

  always_comb begin
    dec_state_d = dec_state_q;
    if (scan_valid) begin
      case (dec_state_q)
        DEC_NORMAL: begin
          if (scan_code == SC_EXT)      dec_state_d = DEC_EXT;
          else if (scan_code == SC_BRK) dec_state_d = DEC_BRK;
        end
        DEC_EXT: dec_state_d = (scan_code == SC_BRK) ? DEC_EXT_BRK : DEC_NORMAL;
        default: dec_state_d = DEC_NORMAL;
      endcase
    end
  end

  // Last-make is tagged with the extended flag so E0-prefixed keys never
  // match their non-extended twins (e.g. arrow vs keypad digit).
  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    ev_ext   = 1'b0;
    if (scan_valid) begin
      case (dec_state_q)
        DEC_NORMAL:  is_make = (scan_code != SC_EXT) && (scan_code != SC_BRK);
        DEC_EXT: begin
          is_make = (scan_code != SC_BRK);
          ev_ext  = 1'b1;
        end
        DEC_BRK:     is_break = 1'b1;
        DEC_EXT_BRK: begin
          is_break = 1'b1;
          ev_ext   = 1'b1;
        end
        default: ;
      endcase
    end
    xlated      = ps2_translate(scan_code, ev_ext, lshift_q | rshift_q);
    key_d       = key_q;
    last_make_d = last_make_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    if (is_make) begin
      if (!ev_ext && scan_code == SC_LSHIFT) lshift_d = 1'b1;
      if (!ev_ext && scan_code == SC_RSHIFT) rshift_d = 1'b1;
      if (xlated != 16'd0) begin
        key_d       = xlated;
        last_make_d = {ev_ext, scan_code};
      end
    end
    if (is_break) begin
      if (!ev_ext && scan_code == SC_LSHIFT) lshift_d = 1'b0;
      if (!ev_ext && scan_code == SC_RSHIFT) rshift_d = 1'b0;
      if ({ev_ext, scan_code} == last_make_q) key_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q       <= '0;
      last_make_q <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
    end else begin
      key_q       <= key_d;
      last_make_q <= last_make_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
    end
  end

  assign key_out = key_q;

endmodule
